lu_arbiter: RTL and testbench

- Shares one 4-bit logic unit between two requesters.
- The logic unit computes AND, OR, XOR or NOR of operands A and B, selected by a 2-bit function code.
- Each requester uses a valid/ready handshake. Grants are round-robin. Each result is registered with the requester id and a backpressure handshake.
- Sits between board-level operand sources (switch/sequencer front ends) and the 7-segment/LED result display path. Per-requester activity counters are exposed for debug.

---
 rtl/lu_pkg.sv | 22 ++
 rtl/lu_core.sv | 30 +++
 rtl/lu_arbiter.sv | 141 ++++++++++++++
 tb/tb_lu_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/lu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lu_pkg
// Description : Shared types for the two-requester logic-unit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lu_pkg;

  typedef enum logic [1:0] {
    LU_AND = 2'd0,
    LU_OR  = 2'd1,
    LU_XOR = 2'd2,
    LU_NOR = 2'd3
  } lu_func_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lu_state_t;

endpackage : lu_pkg
`default_nettype wire

// File: rtl/lu_core.sv
`default_nettype none
// ============================================================================
// Module      : lu_core
// Description : Combinational bitwise logic unit (AND/OR/XOR/NOR).
// Revision    : 1.0 - initial release
// ============================================================================
module lu_core
  import lu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  lu_func_t     f,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (f)
      LU_AND:  y = a & b;
      LU_OR:   y = a | b;
      LU_XOR:  y = a ^ b;
      LU_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule : lu_core
`default_nettype wire

// File: rtl/lu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lu_arbiter
// Description : Round-robin sharing of one logic unit between two requesters,
//               with a registered, backpressured result stage and grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
module lu_arbiter
  import lu_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             in0_valid,
  input  logic [W-1:0]     in0_a,
  input  logic [W-1:0]     in0_b,
  input  logic [1:0]       in0_f,
  output logic             in0_ready,

  input  logic             in1_valid,
  input  logic [W-1:0]     in1_a,
  input  logic [W-1:0]     in1_b,
  input  logic [1:0]       in1_f,
  output logic             in1_ready,

  output logic             out_valid,
  output logic [W-1:0]     out_y,
  output logic             out_id,
  output logic [1:0]       out_f,
  input  logic             out_ready,

  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  lu_state_t        state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [W-1:0]     out_y_q, out_y_d;
  logic             out_id_q, out_id_d;
  logic [1:0]       out_f_q, out_f_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             w_accept_en;
  logic             w_pref;
  logic             w_gnt_valid;
  logic             w_gnt_id;
  logic             w_accept;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [1:0]       w_f;
  logic [W-1:0]     w_y;

  // The result slot can take a new operation when it is empty or draining now.
  assign w_accept_en = (state_q == EMPTY) || out_ready;
  assign w_pref      = ~last_grant_q;

  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_id    = 1'b0;
    if (w_pref ? in1_valid : in0_valid) begin
      w_gnt_valid = 1'b1;
      w_gnt_id    = w_pref;
    end else if (w_pref ? in0_valid : in1_valid) begin
      w_gnt_valid = 1'b1;
      w_gnt_id    = ~w_pref;
    end
  end

  assign in0_ready = ~reset & w_accept_en & w_gnt_valid & (w_gnt_id == 1'b0);
  assign in1_ready = ~reset & w_accept_en & w_gnt_valid & (w_gnt_id == 1'b1);
  // A grant only exists for a valid requester, so a high ready is an acceptance.
  assign w_accept  = in0_ready | in1_ready;

  assign w_a = w_gnt_id ? in1_a : in0_a;
  assign w_b = w_gnt_id ? in1_b : in0_b;
  assign w_f = w_gnt_id ? in1_f : in0_f;

  lu_core #(
    .W (W)
  ) u_core (
    .a (w_a),
    .b (w_b),
    .f (lu_func_t'(w_f)),
    .y (w_y)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_y_d      = out_y_q;
    out_id_d     = out_id_q;
    out_f_d      = out_f_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;

    if (w_accept) begin
      state_d      = FULL;
      last_grant_d = w_gnt_id;
      out_y_d      = w_y;
      out_id_d     = w_gnt_id;
      out_f_d      = w_f;
      if (w_gnt_id) cnt1_d = cnt1_q + CNT_W'(1);
      else          cnt0_d = cnt0_q + CNT_W'(1);
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      out_y_q      <= '0;
      out_id_q     <= 1'b0;
      out_f_q      <= 2'd0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_y_q      <= out_y_d;
      out_id_q     <= out_id_d;
      out_f_q      <= out_f_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_y     = out_y_q;
  assign out_id    = out_id_q;
  assign out_f     = out_f_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule : lu_arbiter
`default_nettype wire

// File: tb/tb_lu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lu_arbiter
// Description : Directed self-checking bench for lu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lu_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       in0_valid, in1_valid;
  logic [3:0] in0_a, in0_b, in1_a, in1_b;
  logic [1:0] in0_f, in1_f;
  logic       in0_ready, in1_ready;
  logic       out_valid, out_id, out_ready;
  logic [3:0] out_y;
  logic [1:0] out_f;
  logic [7:0] cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  lu_arbiter #(.W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in0_valid (in0_valid),
    .in0_a     (in0_a),
    .in0_b     (in0_b),
    .in0_f     (in0_f),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_a     (in1_a),
    .in1_b     (in1_b),
    .in1_f     (in1_f),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_y     (out_y),
    .out_id    (out_id),
    .out_f     (out_f),
    .out_ready (out_ready),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] y,
                         input logic id, input logic [1:0] f);
    chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
    chk({tag, ".y"},     {4'd0, out_y},     {4'd0, y});
    chk({tag, ".id"},    {7'd0, out_id},    {7'd0, id});
    chk({tag, ".f"},     {6'd0, out_f},     {6'd0, f});
  endtask

  logic [3:0] exp_y;
  logic       exp_id;
  logic [1:0] exp_f;

  initial begin
    reset = 1'b1; out_ready = 1'b0;
    in0_valid = 1'b0; in0_a = '0; in0_b = '0; in0_f = '0;
    in1_valid = 1'b0; in1_a = '0; in1_b = '0; in1_f = '0;
    step(); step();

    // Reset state; readies forced low even with a valid request.
    in0_valid = 1'b1; #1;
    chk("rst.in0_ready", {7'd0, in0_ready}, 8'd0);
    chk_out("rst", 1'b0, 4'h0, 1'b0, 2'd0);
    chk("rst.cnt0", cnt0, 8'd0);
    chk("rst.cnt1", cnt1, 8'd0);

    // First op: C & A = 8 from requester 0.
    step();
    reset = 1'b0; out_ready = 1'b1;
    in0_a = 4'hC; in0_b = 4'hA; in0_f = 2'd0; #1;
    chk("and.in0_ready", {7'd0, in0_ready}, 8'd1);
    chk("and.in1_ready", {7'd0, in1_ready}, 8'd0);
    step();
    in0_valid = 1'b0;
    chk_out("and", 1'b1, 4'h8, 1'b0, 2'd0);
    chk("and.cnt0", cnt0, 8'd1);

    // Both valid: last grant was 0, so requester 1 leads, then alternation.
    in0_valid = 1'b1; in0_a = 4'hF; in0_b = 4'h3; in0_f = 2'd2;
    in1_valid = 1'b1; in1_a = 4'h5; in1_b = 4'hA; in1_f = 2'd1; #1;
    chk("rr.in1_ready", {7'd0, in1_ready}, 8'd1);
    chk("rr.in0_ready", {7'd0, in0_ready}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      exp_id = (i % 2 == 0) ? 1'b1 : 1'b0;
      exp_y  = exp_id ? 4'hF : 4'hC;
      exp_f  = exp_id ? 2'd1 : 2'd2;
      chk_out("rr", 1'b1, exp_y, exp_id, exp_f);
    end
    chk("rr.cnt0", cnt0, 8'd3);
    chk("rr.cnt1", cnt1, 8'd2);

    // Drain to empty.
    in0_valid = 1'b0; in1_valid = 1'b0;
    step();
    chk("drain.valid", {7'd0, out_valid}, 8'd0);

    // XOR 6^3 = 5 accepted from EMPTY even with out_ready low.
    out_ready = 1'b0;
    in0_valid = 1'b1; in0_a = 4'h6; in0_b = 4'h3; in0_f = 2'd2; #1;
    chk("xor.in0_ready", {7'd0, in0_ready}, 8'd1);
    step();
    in0_valid = 1'b0;
    chk_out("xor", 1'b1, 4'h5, 1'b0, 2'd2);
    chk("xor.cnt0", cnt0, 8'd4);

    // Backpressure: FULL, out_ready low for 3 cycles, in1 waiting (NOR 0,0).
    in1_valid = 1'b1; in1_a = 4'h0; in1_b = 4'h0; in1_f = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.in1_ready", {7'd0, in1_ready}, 8'd0);
      step();
      chk_out("bp.hold", 1'b1, 4'h5, 1'b0, 2'd2);
    end
    out_ready = 1'b1; #1;
    chk("bp.release_ready", {7'd0, in1_ready}, 8'd1);
    step();
    chk_out("nor00", 1'b1, 4'hF, 1'b1, 2'd3);
    chk("nor00.cnt1", cnt1, 8'd3);

    // NOR F,0 = 0; only in1 valid so it wins despite preference for 0.
    in1_a = 4'hF; in1_b = 4'h0; #1;
    chk("norF0.in1_ready", {7'd0, in1_ready}, 8'd1);
    step();
    in1_valid = 1'b0;
    chk_out("norF0", 1'b1, 4'h0, 1'b1, 2'd3);
    chk("norF0.cnt1", cnt1, 8'd4);

    // Fill with both valid, then reset while FULL.
    in0_valid = 1'b1; in0_a = 4'hC; in0_b = 4'hA; in0_f = 2'd0;
    in1_valid = 1'b1; #1;
    chk("pre.in0_ready", {7'd0, in0_ready}, 8'd1);
    step();
    chk("pre.valid", {7'd0, out_valid}, 8'd1);
    reset = 1'b1; #1;
    chk("midrst.in0_ready", {7'd0, in0_ready}, 8'd0);
    chk("midrst.in1_ready", {7'd0, in1_ready}, 8'd0);
    step();
    chk("midrst.valid", {7'd0, out_valid}, 8'd0);
    chk("midrst.cnt0", cnt0, 8'd0);
    chk("midrst.cnt1", cnt1, 8'd0);
    reset = 1'b0; #1;
    chk("postrst.in0_ready", {7'd0, in0_ready}, 8'd1);
    chk("postrst.in1_ready", {7'd0, in1_ready}, 8'd0);
    in1_valid = 1'b0;

    // 256 back-to-back accepts from in0 wrap cnt0 to 0.
    for (int i = 0; i < 255; i++) step();
    chk("wrap.cnt0_255", cnt0, 8'd255);
    chk_out("wrap.out", 1'b1, 4'h8, 1'b0, 2'd0);
    step();
    chk("wrap.cnt0", cnt0, 8'd0);
    chk("wrap.cnt1", cnt1, 8'd0);
    in0_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_lu_arbiter
`default_nettype wire
